// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the I/D bus arbiter: FSM states and bus size codes.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GNT_I = 2'b01,
        ST_GNT_D = 2'b10
    } state_t;

    localparam logic [1:0] SIZ_NONE  = 2'b00;
    localparam logic [1:0] SIZ_WORD  = 2'b10;
    localparam logic [1:0] SIZ_DWORD = 2'b11;

    function automatic logic is_req(input logic [1:0] siz);
        return siz != SIZ_NONE;
    endfunction

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// Stall watchdog: counts granted cycles without ack, flags the last allowed one.
module bus_arbiter_watchdog #(
    parameter int CW      = 5,
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = (cnt_q == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Shares one external bus between the instruction-fetch (I) and load/store (D)
// masters; one grant at a time, ended by ack, watchdog timeout or request drop.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter bit D_PRIORITY = 1'b1,
    parameter int TIMEOUT    = 16,
    parameter int CW         = 5
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [63:0] iadr_i,
    input  logic [1:0]  isiz_i,
    output logic [31:0] idat_o,
    output logic        iack_o,
    output logic        ierr_o,
    input  logic [63:0] dadr_i,
    input  logic [1:0]  dsiz_i,
    input  logic        dwe_i,
    input  logic [63:0] ddat_i,
    output logic [63:0] ddat_o,
    output logic        dack_o,
    output logic        derr_o,
    output logic [63:0] xadr_o,
    output logic [1:0]  xsiz_o,
    output logic        xwe_o,
    output logic [63:0] xdat_o,
    input  logic [63:0] xdat_i,
    input  logic        xack_i
);

    state_t state_q, state_d;
    logic   tie_d_q, tie_d_d;
    logic   ireq, dreq;
    logic   gnt_i, gnt_d;
    logic   timeout;

    assign ireq  = is_req(isiz_i);
    assign dreq  = is_req(dsiz_i);
    assign gnt_i = (state_q == ST_GNT_I);
    assign gnt_d = (state_q == ST_GNT_D);

    bus_arbiter_watchdog #(
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clr_i     (state_q == ST_IDLE),
        .en_i      ((gnt_i | gnt_d) & ~xack_i),
        .timeout_o (timeout)
    );

    // tie_d_q set means D wins the next simultaneous request
    always_comb begin
        state_d = state_q;
        tie_d_d = tie_d_q;
        unique case (state_q)
            ST_IDLE: begin
                if (dreq && (!ireq || D_PRIORITY || tie_d_q)) begin
                    state_d = ST_GNT_D;
                    tie_d_d = 1'b0;
                end else if (ireq) begin
                    state_d = ST_GNT_I;
                    tie_d_d = 1'b1;
                end
            end
            ST_GNT_I: begin
                if (xack_i || timeout || !ireq) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT_D: begin
                if (xack_i || timeout || !dreq) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            tie_d_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tie_d_q <= tie_d_d;
        end
    end

    assign xadr_o = ({64{gnt_i}} & iadr_i) | ({64{gnt_d}} & dadr_i);
    assign xsiz_o = ({2{gnt_i}} & isiz_i) | ({2{gnt_d}} & dsiz_i);
    assign xwe_o  = gnt_d & dwe_i;
    assign xdat_o = {64{gnt_d}} & ddat_i;

    assign idat_o = {32{gnt_i}} & xdat_i[31:0];
    assign ddat_o = {64{gnt_d}} & xdat_i;

    // a dropped request gets neither ack nor error
    assign iack_o = gnt_i & ireq & xack_i;
    assign ierr_o = gnt_i & ireq & timeout & ~xack_i;
    assign dack_o = gnt_d & dreq & xack_i;
    assign derr_o = gnt_d & dreq & timeout & ~xack_i;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic on two instances.
module tb_bus_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] iadr = '0, dadr = '0, ddat = '0, xdat = '0;
    logic [1:0]  isiz = '0, dsiz = '0;
    logic        dwe = 1'b0, xack = 1'b0;

    logic [31:0] a_idat, b_idat;
    logic        a_iack, a_ierr, b_iack, b_ierr;
    logic [63:0] a_ddat, b_ddat;
    logic        a_dack, a_derr, b_dack, b_derr;
    logic [63:0] a_xadr, b_xadr, a_xdat, b_xdat;
    logic [1:0]  a_xsiz, b_xsiz;
    logic        a_xwe, b_xwe;

    typedef struct packed {
        logic [63:0] xadr;
        logic [1:0]  xsiz;
        logic        xwe;
        logic [63:0] xdat;
        logic [31:0] idat;
        logic        iack;
        logic        ierr;
        logic [63:0] ddat;
        logic        dack;
        logic        derr;
    } ovec_t;

    ovec_t oa, ob;

    int checks = 0;
    int failures = 0;

    int own[2];
    int gc[2];
    bit iwin[2];

    always #5 clk = ~clk;

    bus_arbiter #(.D_PRIORITY(1'b1), .TIMEOUT(TO), .CW(5)) u_dp (
        .clk_i(clk), .reset_i(reset),
        .iadr_i(iadr), .isiz_i(isiz), .idat_o(a_idat),
        .iack_o(a_iack), .ierr_o(a_ierr),
        .dadr_i(dadr), .dsiz_i(dsiz), .dwe_i(dwe), .ddat_i(ddat),
        .ddat_o(a_ddat), .dack_o(a_dack), .derr_o(a_derr),
        .xadr_o(a_xadr), .xsiz_o(a_xsiz), .xwe_o(a_xwe),
        .xdat_o(a_xdat), .xdat_i(xdat), .xack_i(xack)
    );

    bus_arbiter #(.D_PRIORITY(1'b0), .TIMEOUT(TO), .CW(5)) u_rr (
        .clk_i(clk), .reset_i(reset),
        .iadr_i(iadr), .isiz_i(isiz), .idat_o(b_idat),
        .iack_o(b_iack), .ierr_o(b_ierr),
        .dadr_i(dadr), .dsiz_i(dsiz), .dwe_i(dwe), .ddat_i(ddat),
        .ddat_o(b_ddat), .dack_o(b_dack), .derr_o(b_derr),
        .xadr_o(b_xadr), .xsiz_o(b_xsiz), .xwe_o(b_xwe),
        .xdat_o(b_xdat), .xdat_i(xdat), .xack_i(xack)
    );

    assign oa = {a_xadr, a_xsiz, a_xwe, a_xdat, a_idat,
                 a_iack, a_ierr, a_ddat, a_dack, a_derr};
    assign ob = {b_xadr, b_xsiz, b_xwe, b_xdat, b_idat,
                 b_iack, b_ierr, b_ddat, b_dack, b_derr};

    // Reference: own 0=none 1=I 2=D; gc = granted cycles already completed
    function automatic ovec_t expect_out(input int k);
        ovec_t e;
        e = '0;
        if (own[k] == 1) begin
            e.xadr = iadr;
            e.xsiz = isiz;
            e.idat = xdat[31:0];
            if (isiz != 2'b00) begin
                e.iack = xack;
                e.ierr = !xack && (gc[k] + 1 == TO);
            end
        end else if (own[k] == 2) begin
            e.xadr = dadr;
            e.xsiz = dsiz;
            e.xwe  = dwe;
            e.xdat = ddat;
            e.ddat = xdat;
            if (dsiz != 2'b00) begin
                e.dack = xack;
                e.derr = !xack && (gc[k] + 1 == TO);
            end
        end
        return e;
    endfunction

    function automatic void model_step(input int k);
        bit ir, dr, req;
        ir = (isiz != 2'b00);
        dr = (dsiz != 2'b00);
        if (reset) begin
            own[k] = 0;
            gc[k] = 0;
            iwin[k] = 1'b1;
        end else if (own[k] == 0) begin
            if (ir && dr) own[k] = (k == 0 || !iwin[k]) ? 2 : 1;
            else if (dr) own[k] = 2;
            else if (ir) own[k] = 1;
            if (own[k] != 0) iwin[k] = (own[k] == 2);
            gc[k] = 0;
        end else begin
            req = (own[k] == 1) ? ir : dr;
            gc[k] = gc[k] + 1;
            if (xack || gc[k] == TO || !req) begin
                own[k] = 0;
                gc[k] = 0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        isiz = '0;
        dsiz = '0;
        dwe = 1'b0;
        xack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        isiz = 2'b11;
        dsiz = 2'b11;
        xack = 1'b1;
        iadr = 64'hDEAD_BEEF_0000_1234;
        dadr = 64'h1111_2222_3333_4444;
        #1;
        checks++;
        if (oa !== '0) begin
            failures++;
            $display("FAIL reset_a got=%h exp=0", oa);
        end
        checks++;
        if (ob !== '0) begin
            failures++;
            $display("FAIL reset_b got=%h exp=0", ob);
        end
        do_reset();
        dsiz = 2'b11;
        tick();
        checks++;
        if (a_xsiz !== 2'b11) begin
            failures++;
            $display("FAIL rst_pre_gnt got=%b exp=11", a_xsiz);
        end
        xack = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (a_xsiz !== 2'b00 || a_dack !== 1'b0) begin
            failures++;
            $display("FAIL rst_async got=%b/%b exp=00/0", a_xsiz, a_dack);
        end
        checks++;
        if (oa !== '0 || ob !== '0) begin
            failures++;
            $display("FAIL rst_async_all got=%h exp=0", oa);
        end
        tick();
        reset = 1'b0;
        dsiz = '0;
        xack = 1'b0;
        #1;
        checks++;
        if (a_xsiz !== 2'b00) begin
            failures++;
            $display("FAIL rst_idle got=%b exp=00", a_xsiz);
        end
    endtask

    task automatic test_i_only();
        logic [63:0] v;
        do_reset();
        v = {$urandom, $urandom};
        iadr = 64'hFFFF_FFFF_FFFF_FF00;
        isiz = 2'b10;
        #1;
        checks++;
        if (a_xsiz !== 2'b00) begin
            failures++;
            $display("FAIL i_latency got=%b exp=00", a_xsiz);
        end
        tick();
        checks++;
        if (a_xadr !== 64'hFFFF_FFFF_FFFF_FF00 || a_xsiz !== 2'b10 ||
            a_xwe !== 1'b0 || a_iack !== 1'b0) begin
            failures++;
            $display("FAIL i_grant got=%h/%b/%b/%b exp=..ff00/10/0/0",
                     a_xadr, a_xsiz, a_xwe, a_iack);
        end
        tick();
        checks++;
        if (a_iack !== 1'b0) begin
            failures++;
            $display("FAIL i_noack got=%b exp=0", a_iack);
        end
        tick();
        xdat = v;
        xack = 1'b1;
        #1;
        checks++;
        if (a_iack !== 1'b1 || a_idat !== v[31:0] || a_dack !== 1'b0) begin
            failures++;
            $display("FAIL i_ack got=%b/%h/%b exp=1/%h/0",
                     a_iack, a_idat, a_dack, v[31:0]);
        end
        tick();
        xack = 1'b0;
        isiz = '0;
        #1;
        checks++;
        if (a_xsiz !== 2'b00 || a_iack !== 1'b0 || a_idat !== 32'h0) begin
            failures++;
            $display("FAIL i_done got=%b/%b/%h exp=00/0/0",
                     a_xsiz, a_iack, a_idat);
        end
    endtask

    task automatic test_tie_dprio();
        logic [63:0] wd;
        do_reset();
        wd = {$urandom, $urandom};
        ddat = wd;
        dadr = {$urandom, $urandom};
        dwe = 1'b1;
        isiz = 2'b10;
        dsiz = 2'b11;
        tick();
        checks++;
        if (a_xsiz !== 2'b11 || a_xwe !== 1'b1 || a_xdat !== wd ||
            a_xadr !== dadr) begin
            failures++;
            $display("FAIL tie_dp_grant got=%b/%b/%h exp=11/1/%h",
                     a_xsiz, a_xwe, a_xdat, wd);
        end
        xack = 1'b1;
        #1;
        checks++;
        if (a_dack !== 1'b1 || a_iack !== 1'b0) begin
            failures++;
            $display("FAIL tie_dp_dack got=%b/%b exp=1/0", a_dack, a_iack);
        end
        tick();
        dsiz = '0;
        dwe = 1'b0;
        xack = 1'b0;
        #1;
        checks++;
        if (a_xsiz !== 2'b00 || a_iack !== 1'b0) begin
            failures++;
            $display("FAIL tie_dp_bubble got=%b/%b exp=00/0", a_xsiz, a_iack);
        end
        tick();
        checks++;
        if (a_xsiz !== 2'b10 || a_xwe !== 1'b0) begin
            failures++;
            $display("FAIL tie_dp_then_i got=%b/%b exp=10/0", a_xsiz, a_xwe);
        end
        xack = 1'b1;
        #1;
        checks++;
        if (a_iack !== 1'b1 || a_dack !== 1'b0) begin
            failures++;
            $display("FAIL tie_dp_iack got=%b/%b exp=1/0", a_iack, a_dack);
        end
        tick();
        isiz = '0;
        xack = 1'b0;
    endtask

    task automatic test_tie_rr();
        logic [1:0] want[3];
        want[0] = 2'b10;
        want[1] = 2'b11;
        want[2] = 2'b10;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            isiz = 2'b10;
            dsiz = 2'b11;
            tick();
            checks++;
            if (b_xsiz !== want[p]) begin
                failures++;
                $display("FAIL tie_rr_%0d got=%b exp=%b", p, b_xsiz, want[p]);
            end
            xack = 1'b1;
            #1;
            checks++;
            if ({b_iack, b_dack} !== ((want[p] == 2'b10) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL tie_rr_ack_%0d got=%b%b", p, b_iack, b_dack);
            end
            tick();
            isiz = '0;
            dsiz = '0;
            xack = 1'b0;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        dsiz = 2'b11;
        tick();
        for (int n = 1; n <= TO; n++) begin
            checks++;
            if (a_derr !== (n == TO) || a_dack !== 1'b0) begin
                failures++;
                $display("FAIL tmo_cyc%0d got=%b/%b exp=%b/0",
                         n, a_derr, a_dack, (n == TO));
            end
            tick();
        end
        checks++;
        if (a_xsiz !== 2'b00 || a_derr !== 1'b0) begin
            failures++;
            $display("FAIL tmo_idle got=%b/%b exp=00/0", a_xsiz, a_derr);
        end
        dsiz = '0;
        tick();
        dsiz = 2'b11;
        tick();
        for (int n = 1; n < TO; n++) tick();
        xack = 1'b1;
        #1;
        checks++;
        if (a_dack !== 1'b1 || a_derr !== 1'b0) begin
            failures++;
            $display("FAIL tmo_ackwins got=%b/%b exp=1/0", a_dack, a_derr);
        end
        tick();
        xack = 1'b0;
        dsiz = '0;
        #1;
        checks++;
        if (a_xsiz !== 2'b00) begin
            failures++;
            $display("FAIL tmo_ack_idle got=%b exp=00", a_xsiz);
        end
    endtask

    task automatic test_drop();
        do_reset();
        isiz = 2'b10;
        tick();
        checks++;
        if (a_xsiz !== 2'b10) begin
            failures++;
            $display("FAIL drop_grant got=%b exp=10", a_xsiz);
        end
        tick();
        isiz = '0;
        #1;
        checks++;
        if (a_iack !== 1'b0 || a_xsiz !== 2'b00) begin
            failures++;
            $display("FAIL drop_cyc got=%b/%b exp=0/00", a_iack, a_xsiz);
        end
        tick();
        xack = 1'b1;
        #1;
        checks++;
        if ({a_iack, a_dack, b_iack, b_dack} !== 4'b0000) begin
            failures++;
            $display("FAIL stray_ack got=%b%b%b%b exp=0000",
                     a_iack, a_dack, b_iack, b_dack);
        end
        tick();
        checks++;
        if (a_xsiz !== 2'b00 || b_xsiz !== 2'b00) begin
            failures++;
            $display("FAIL stray_idle got=%b/%b exp=00/00", a_xsiz, b_xsiz);
        end
        xack = 1'b0;
    endtask

    task automatic test_random();
        bit ipend, dpend, idone, ddone, slow;
        ovec_t ea, eb;
        ipend = 0;
        dpend = 0;
        idone = 0;
        ddone = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            slow = ((c / 250) % 2) == 1;
            if (idone) begin
                ipend = 0;
                isiz = '0;
            end
            if (ddone) begin
                dpend = 0;
                dsiz = '0;
            end
            if (!ipend && $urandom_range(2) == 0) begin
                ipend = 1;
                isiz = 2'($urandom_range(1, 3));
                iadr = {$urandom, $urandom};
            end else if (ipend && $urandom_range(59) == 0) begin
                ipend = 0;
                isiz = '0;
            end
            if (!dpend && $urandom_range(2) == 0) begin
                dpend = 1;
                dsiz = 2'($urandom_range(1, 3));
                dadr = {$urandom, $urandom};
                ddat = {$urandom, $urandom};
                dwe = 1'($urandom_range(1));
            end else if (dpend && $urandom_range(59) == 0) begin
                dpend = 0;
                dsiz = '0;
            end
            xack = slow ? ($urandom_range(39) == 0) : ($urandom_range(2) == 0);
            xdat = {$urandom, $urandom};
            #1;
            ea = expect_out(0);
            eb = expect_out(1);
            checks++;
            if (oa !== ea) begin
                failures++;
                $display("FAIL rnd_dp c=%0d got=%h exp=%h", c, oa, ea);
            end
            checks++;
            if (ob !== eb) begin
                failures++;
                $display("FAIL rnd_rr c=%0d got=%h exp=%h", c, ob, eb);
            end
            idone = ea.iack | ea.ierr;
            ddone = ea.dack | ea.derr;
            tick();
        end
        isiz = '0;
        dsiz = '0;
        xack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_i_only();
        test_tie_dprio();
        test_tie_rr();
        test_timeout();
        test_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
